// File: rtl/wishbone_gpio_slave_if.sv
// ----------------------------------------------------------------------------
// wishbone_gpio_slave_if
// Wishbone classic bus bundle between an interconnect master and the GPIO
// slave. Signal names keep the slave's point of view (_i into the slave,
// _o out of the slave).
//   addr_i  [31:0]  byte address
//   we_i            1 = write, 0 = read
//   sel_i   [3:0]   byte-lane enables for writes
//   data_i  [31:0]  write data
//   cyc_i           bus cycle
//   stb_i           strobe
//   data_o  [31:0]  read data, valid while ack_o = 1, else 0
//   ack_o           transfer acknowledge
// ----------------------------------------------------------------------------
interface wishbone_gpio_slave_if;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [31:0] data_i;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output addr_i, we_i, sel_i, data_i, cyc_i, stb_i,
    input  data_o, ack_o
  );

  modport slave (
    input  addr_i, we_i, sel_i, data_i, cyc_i, stb_i,
    output data_o, ack_o
  );
endinterface

// File: rtl/wishbone_gpio_slave.sv
// ----------------------------------------------------------------------------
// wishbone_gpio_slave
// Wishbone classic GPIO slave: output latch with atomic set/clear/toggle,
// synchronised inputs, rising-edge status (write-1-to-clear) and a maskable,
// registered level interrupt.
// Ports:
//   clk_i            clock, all logic on the rising edge
//   rst_i            synchronous reset, active-high
//   wb               Wishbone bus bundle (slave modport)
//   gpio_i [W-1:0]   asynchronous pin inputs
//   gpio_o [W-1:0]   pin outputs (optionally inverted OUT latch)
//   irq_o            level interrupt = |(RISE & IEN), registered
// Register map (addr_i[4:2]):
//   0 OUT  1 SET  2 CLR  3 TGL  4 IN  5 RISE  6 IEN  7 reserved
// ----------------------------------------------------------------------------
module wishbone_gpio_slave #(
  parameter int unsigned GPIO_WIDTH  = 8,
  parameter logic [31:0] OUT_RESET   = 32'h0,
  parameter bit          INVERT_OUT  = 1'b1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  wishbone_gpio_slave_if.slave  wb,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic                  irq_o
);

  localparam logic [GPIO_WIDTH-1:0] L_OUT_RESET = OUT_RESET[GPIO_WIDTH-1:0];

  localparam logic [2:0] REG_OUT  = 3'd0;
  localparam logic [2:0] REG_SET  = 3'd1;
  localparam logic [2:0] REG_CLR  = 3'd2;
  localparam logic [2:0] REG_TGL  = 3'd3;
  localparam logic [2:0] REG_IN   = 3'd4;
  localparam logic [2:0] REG_RISE = 3'd5;
  localparam logic [2:0] REG_IEN  = 3'd6;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                         r_state;
  logic                           r_ack;
  logic [31:0]                    r_data;
  logic [GPIO_WIDTH-1:0]          r_out;
  logic [GPIO_WIDTH-1:0]          r_ien;
  logic [GPIO_WIDTH-1:0]          r_rise;
  logic [GPIO_WIDTH-1:0]          r_hist;
  logic                           r_irq;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] r_sync;

  logic                  w_req;
  logic                  w_start;
  logic                  w_wr;
  logic [2:0]            w_reg;
  logic [31:0]           w_lane_mask;
  logic [31:0]           w_d32;
  logic [GPIO_WIDTH-1:0] w_d;
  logic [GPIO_WIDTH-1:0] w_m;
  logic [GPIO_WIDTH-1:0] w_sync;
  logic [GPIO_WIDTH-1:0] w_edge;
  logic [GPIO_WIDTH-1:0] w_rise_clr;
  logic [GPIO_WIDTH-1:0] w_rise_next;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_req   = wb.cyc_i & wb.stb_i;
  // A transfer is accepted only from IDLE, so a held strobe commits once.
  assign w_start = (r_state == ST_IDLE) & w_req;
  assign w_wr    = w_start & wb.we_i;
  assign w_reg   = wb.addr_i[4:2];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_lane_mask[gi*8 +: 8] = {8{wb.sel_i[gi]}};
    end
  endgenerate

  // Unselected lanes read as 0 in d; OUT/IEN use the mask to keep old bytes.
  assign w_d32 = wb.data_i & w_lane_mask;
  assign w_d   = w_d32[GPIO_WIDTH-1:0];
  assign w_m   = w_lane_mask[GPIO_WIDTH-1:0];

  // Address bits outside [4:2] and data/lane bits above GPIO_WIDTH are ignored.
  assign w_unused = ^{wb.addr_i[31:5], wb.addr_i[1:0], w_d32, w_lane_mask};

  // Input synchroniser chain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_edge = w_sync & ~r_hist;

  // A new edge on a bit wins over a same-cycle write-1-to-clear.
  assign w_rise_clr  = (w_wr && (w_reg == REG_RISE)) ? w_d : '0;
  assign w_rise_next = (r_rise & ~w_rise_clr) | w_edge;

  // Register file.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_out  <= L_OUT_RESET;
      r_ien  <= '0;
      r_rise <= '0;
      r_hist <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_hist <= w_sync;
      r_rise <= w_rise_next;
      r_irq  <= |(r_rise & r_ien);
      if (w_wr) begin
        case (w_reg)
          REG_OUT: r_out <= (r_out & ~w_m) | w_d;
          REG_SET: r_out <= r_out | w_d;
          REG_CLR: r_out <= r_out & ~w_d;
          REG_TGL: r_out <= r_out ^ w_d;
          REG_IEN: r_ien <= (r_ien & ~w_m) | w_d;
          default: ;
        endcase
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_OUT, REG_SET, REG_CLR, REG_TGL: w_rdata[GPIO_WIDTH-1:0] = r_out;
      REG_IN:   w_rdata[GPIO_WIDTH-1:0] = w_sync;
      REG_RISE: w_rdata[GPIO_WIDTH-1:0] = r_rise;
      REG_IEN:  w_rdata[GPIO_WIDTH-1:0] = r_ien;
      default:  w_rdata = '0;
    endcase
  end

  // Bus handshake FSM with registered ack and read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_ack   <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_state <= ST_ACTIVE;
            r_ack   <= 1'b1;
            r_data  <= wb.we_i ? 32'h0 : w_rdata;
          end
        end
        ST_ACTIVE: begin
          if (!w_req) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
            r_data  <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_data  <= '0;
        end
      endcase
    end
  end

  assign wb.ack_o  = r_ack;
  assign wb.data_o = r_data;
  assign gpio_o    = INVERT_OUT ? ~r_out : r_out;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_wishbone_gpio_slave.sv
// ----------------------------------------------------------------------------
// tb_wishbone_gpio_slave
// Directed bench for the GPIO slave: an 8-bit inverted instance and a 32-bit
// non-inverted instance share one master driver; read results are matched
// against a queue of expected values pushed when each read is issued.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wishbone_gpio_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        target;   // 0: 8-bit instance, 1: 32-bit instance
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic        m_we;
  logic [3:0]  m_sel;
  logic        m_cyc;
  logic        m_stb;

  wishbone_gpio_slave_if bus8();
  wishbone_gpio_slave_if bus32();

  assign bus8.addr_i  = m_addr;
  assign bus8.data_i  = m_data;
  assign bus8.we_i    = m_we;
  assign bus8.sel_i   = m_sel;
  assign bus8.cyc_i   = m_cyc & ~target;
  assign bus8.stb_i   = m_stb & ~target;
  assign bus32.addr_i = m_addr;
  assign bus32.data_i = m_data;
  assign bus32.we_i   = m_we;
  assign bus32.sel_i  = m_sel;
  assign bus32.cyc_i  = m_cyc & target;
  assign bus32.stb_i  = m_stb & target;

  logic        w_ack;
  logic [31:0] w_data;
  assign w_ack  = target ? bus32.ack_o  : bus8.ack_o;
  assign w_data = target ? bus32.data_o : bus8.data_o;

  logic [7:0]  gpio_i8, gpio_o8;
  logic        irq8;
  logic [31:0] gpio_i32, gpio_o32;
  logic        irq32;

  wishbone_gpio_slave #(
    .GPIO_WIDTH(8), .OUT_RESET(32'h0), .INVERT_OUT(1'b1), .SYNC_STAGES(2)
  ) u_dut8 (
    .clk_i(clk), .rst_i(rst), .wb(bus8),
    .gpio_i(gpio_i8), .gpio_o(gpio_o8), .irq_o(irq8)
  );

  wishbone_gpio_slave #(
    .GPIO_WIDTH(32), .OUT_RESET(32'h0), .INVERT_OUT(1'b0), .SYNC_STAGES(2)
  ) u_dut32 (
    .clk_i(clk), .rst_i(rst), .wb(bus32),
    .gpio_i(gpio_i32), .gpio_o(gpio_o32), .irq_o(irq32)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_out;
  logic [7:0]  exp_gpio;
  logic [31:0] rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // One bus transfer; strobe is held for 'hold' sampling edges once acked.
  task automatic wb_xfer(input logic [2:0] r, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, input int hold, input string tag,
                         output logic [31:0] rdata);
    int n;
    @(negedge clk);
    m_addr = {27'd0, r, 2'b00};
    m_we   = we;
    m_data = d;
    m_sel  = sel;
    m_cyc  = 1'b1;
    m_stb  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_ack && n < 16);
    check({tag, "_ack_latency"}, n, 32'd1);
    rdata = w_data;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_ack_hold"}, {31'd0, w_ack}, 32'd1);
    end
    m_cyc = 1'b0;
    m_stb = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, {31'd0, w_ack}, 32'd0);
    check({tag, "_data_drop"}, w_data, 32'd0);
    $display("txn %s dut=%0d reg=%0d we=%0b d=0x%08h sel=0x%h rd=0x%08h wait=%0d",
             tag, target ? 32 : 8, r, we, d, sel, rdata, n);
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [31:0] d, input logic [3:0] sel,
                          input int hold, input string tag);
    logic [31:0] dummy;
    wb_xfer(r, 1'b1, d, sel, hold, tag, dummy);
  endtask

  task automatic wb_read(input logic [2:0] r, input logic [31:0] expv, input string tag);
    logic [31:0] got;
    exp_q.push_back(expv);
    wb_xfer(r, 1'b0, 32'h0, 4'h0, 1, tag, got);
    check(tag, got, exp_q.pop_front());
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; target = 1'b0;
    m_addr = '0; m_data = '0; m_we = 1'b0; m_sel = '0; m_cyc = 1'b0; m_stb = 1'b0;
    gpio_i8 = '0; gpio_i32 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_gpio_o8", gpio_o8, 32'hFF);
    check("rst_ack8", bus8.ack_o, 32'd0);
    check("rst_data8", bus8.data_o, 32'd0);
    check("rst_irq8", irq8, 32'd0);
    check("rst_gpio_o32", gpio_o32, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gpio_o8", gpio_o8, 32'hFF);

    // OUT write with strobe held for 3 edges
    wb_write(3'd0, 32'h0000_00A5, 4'hF, 3, "wr_out_a5");
    check("gpio_o8_a5", gpio_o8, 32'h5A);
    wb_read(3'd0, 32'h0000_00A5, "rd_out_a5");

    // Atomic set / clear / toggle
    exp_out = 8'hF0;
    wb_write(3'd0, 32'hF0, 4'hF, 1, "wr_out_f0");
    exp_out = exp_out | 8'h0F;
    wb_write(3'd1, 32'h0F, 4'hF, 1, "wr_set_0f");
    exp_out = exp_out & ~8'h30;
    wb_write(3'd2, 32'h30, 4'hF, 1, "wr_clr_30");
    exp_out = exp_out ^ 8'h81;
    wb_write(3'd3, 32'h81, 4'hF, 4, "wr_tgl_81_hold4");
    wb_read(3'd0, {24'd0, exp_out}, "rd_out_4e");
    wb_read(3'd1, {24'd0, exp_out}, "rd_set_4e");
    wb_read(3'd2, {24'd0, exp_out}, "rd_clr_4e");
    wb_read(3'd3, {24'd0, exp_out}, "rd_tgl_4e");
    exp_gpio = ~exp_out;
    check("gpio_o8_4e", gpio_o8, {24'd0, exp_gpio});

    // Rising edge, interrupt timing
    wb_write(3'd6, 32'h08, 4'hF, 1, "wr_ien_08");
    wb_read(3'd6, 32'h08, "rd_ien_08");
    @(negedge clk);
    gpio_i8 = 8'h08;
    @(negedge clk);
    @(negedge clk);
    check("irq_after_2", irq8, 32'd0);
    @(negedge clk);
    check("irq_after_3", irq8, 32'd0);
    @(negedge clk);
    check("irq_after_4", irq8, 32'd1);
    wb_read(3'd5, 32'h08, "rd_rise_08");
    wb_read(3'd4, 32'h08, "rd_in_08");
    wb_write(3'd5, 32'h08, 4'hF, 1, "w1c_rise_08");
    wb_read(3'd5, 32'h00, "rd_rise_cleared");
    check("irq_cleared", irq8, 32'd0);

    // W1C in the same cycle as a new edge: set wins
    gpio_i8 = 8'h00;
    repeat (4) @(negedge clk);
    gpio_i8 = 8'h08;
    @(posedge clk);
    @(posedge clk);
    wb_write(3'd5, 32'h08, 4'hF, 1, "w1c_vs_edge");
    wb_read(3'd5, 32'h08, "rd_rise_set_wins");
    check("irq_set_wins", irq8, 32'd1);
    wb_write(3'd6, 32'h00, 4'hF, 1, "wr_ien_00");
    wb_read(3'd6, 32'h00, "rd_ien_00");
    check("irq_masked", irq8, 32'd0);

    // 32-bit instance: byte lanes and reserved register
    target = 1'b1;
    wb_write(3'd0, 32'hDEAD_BEEF, 4'b0101, 1, "wr32_out_lanes");
    wb_read(3'd0, 32'h00AD_00EF, "rd32_out_lanes");
    check("gpio_o32_lanes", gpio_o32, 32'h00AD_00EF);
    wb_read(3'd7, 32'h0, "rd32_reserved");
    wb_write(3'd7, 32'hFFFF_FFFF, 4'hF, 1, "wr32_reserved");
    wb_read(3'd0, 32'h00AD_00EF, "rd32_out_after_rsvd");
    target = 1'b0;

    // Reset during an active write; the still-strobing master restarts
    wb_write(3'd0, 32'h33, 4'hF, 1, "wr_out_33");
    @(negedge clk);
    m_addr = 32'h0; m_we = 1'b1; m_data = 32'h77; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    check("mid_ack_before_rst", bus8.ack_o, 32'd1);
    check("mid_gpio_77", gpio_o8, 32'h88);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ack", bus8.ack_o, 32'd0);
    check("mid_rst_gpio", gpio_o8, 32'hFF);
    check("mid_rst_data", bus8.data_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_ack", bus8.ack_o, 32'd1);
    check("restart_gpio", gpio_o8, 32'h88);
    m_cyc = 1'b0; m_stb = 1'b0;
    @(negedge clk);
    check("restart_ack_drop", bus8.ack_o, 32'd0);
    $display("txn rst_mid_write dut=8 reg=0 we=1 d=0x00000077 gpio_o=0x%02h", gpio_o8);

    // Write presented in the reset cycle is dropped
    @(negedge clk);
    rst = 1'b1;
    m_data = 32'h11; m_cyc = 1'b1; m_stb = 1'b1;
    @(negedge clk);
    check("drop_ack", bus8.ack_o, 32'd0);
    m_cyc = 1'b0; m_stb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("drop_gpio", gpio_o8, 32'hFF);
    $display("txn rst_drop_write dut=8 reg=0 we=1 d=0x00000011 gpio_o=0x%02h", gpio_o8);
    wb_read(3'd0, 32'h0, "rd_out_after_drop");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
